knn_stream_classifier: RTL and testbench
========================================

// Module: knn_stream_classifier
// PURPOSE
//  Streaming KNN core, successor to the fixed L1 KNN system. Accepts training/input element pairs over a
//  valid/ready stream, accumulates a per-vector distance (L1 or squared L2, selectable), keeps a sorted
//  top-K neighbour list by single-cycle insertion, then runs a multi-cycle majority vote with a
//  nearest-neighbour tie-break. Vectors may have any length; there is no M*N or MAX_ELEMENTS burst limit.
// PARAMETERS
//  W          32  element width, unsigned
//  TYPE_W     3   class label width; NUM_TYPES = 2**TYPE_W
//  K          7   neighbours kept/voted, K >= 1
//  L          32  training vectors per inference, L >= 1
//  ACC_W      72  distance accumulator width, >= 2*W
// PORTS
//  clk             in   1              clock, rising edge
//  rst             in   1              synchronous active-high reset
//  start           in   1              begin new inference; samples mode
//  mode            in   1              0 = L1 |a-b|, 1 = squared L2 (a-b)^2
//  elem_valid      in   1              element pair valid
//  elem_ready      out  1              element accepted when valid&ready
//  elem_train      in   W              training element
//  elem_input      in   W              input (query) element
//  elem_last       in   1              last element of current training vector
//  vec_type        in   TYPE_W         label of current vector, sampled with elem_last
//  busy            out  1              high in any state except IDLE
//  inferred_type   out  TYPE_W         result, held until next start/rst
//  vote_count      out  clog2(K+1)     votes won by inferred_type
//  inference_done  out  1              one-cycle pulse, result valid
// BEHAVIOUR
//  Reset: state IDLE; elem_ready, busy, inference_done = 0; inferred_type, vote_count = 0;
//   acc, vec_cnt = 0; all list entries invalid. Reset wins over every other input in any state.
//  FSM: IDLE -> ACCUM on start. ACCUM -> INSERT on accepted beat with elem_last.
//   INSERT -> ACCUM if vec_cnt+1 < L, else VOTE. VOTE runs NUM_TYPES cycles -> DONE. DONE -> IDLE.
//  ACCUM: elem_ready = 1. Per beat, acc += |train-input| (mode 0) or (train-input)^2 (mode 1).
//   Difference is computed unsigned with no wrap. Sum saturates at 2**ACC_W-1 and never wraps.
//   A vector of a single beat (elem_last on first beat) is legal.
//  INSERT (1 cycle, elem_ready = 0): new entry {acc, vec_type} is placed before the first valid entry
//   with a strictly greater distance. Equal distances keep arrival order (stable).
//   List full and acc >= entry[K-1]: new entry is discarded. Otherwise entry[K-1] drops off the end.
//   Then acc is cleared and vec_cnt increments.
//  VOTE: one type t per cycle, t = 0..NUM_TYPES-1. Count valid entries labelled t, and record the rank
//   of the first entry labelled t. Best is replaced when count > best count, or count == best count
//   and first rank < best rank. Zero-count types never win.
//   If L < K, only valid entries vote.
//  DONE: inferred_type and vote_count update; inference_done = 1 for exactly this cycle.
//  Latency: inference_done is high NUM_TYPES+2 clocks after the edge that accepts the final elem_last.
//  start while busy: abort. List, acc and vec_cnt are cleared, mode is resampled, go to ACCUM.
//   No inference_done is issued for the aborted run. start in the same cycle as a beat: the beat is dropped.
//  start in DONE is honoured the next cycle.
//  mode changes outside a start cycle are ignored.
// TESTING
//  T1 L1 order: mode 0, 32 one-element vectors, train = i, type = i/4, input 10
//     -> neighbours 10,9,11,8,12,7,13 -> inferred_type 2, vote_count 4.
//  T2 tie-break: input 0; values 1(t1) 2(t4) 3(t4) 4(t1) 5(t4) 6(t1) 7(t5); other 25 vectors value 100 t0
//     -> 3-3 tie -> inferred_type 1.
//  T3 L2 saturation: mode 1, W 32; one vector of 257 beats train 0xFFFFFFFF vs input 0
//     -> acc = all-ones, no wrap; that vector ranks last, result as T1.
//  T4 backpressure: T1 data with random elem_valid gaps and elem_last held across INSERT
//     -> no beat lost or duplicated, identical result to T1.
//  T5 abort: start after 10 vectors, then T2 data
//     -> exactly one inference_done, inferred_type 1.
//  T6 reset mid-VOTE -> outputs 0 next cycle, no inference_done; a following T1 run passes.

Source files
------------

// File: rtl/knn_stream_classifier.sv
// rtl/knn_stream_classifier.sv - streaming KNN core: L1/L2 distance accumulation, sorted top-K insert, majority vote
// Distances saturate; the neighbour list is kept sorted and stable, and the vote breaks ties on nearest rank.
module knn_stream_classifier #(
    parameter int W      = 32,
    parameter int TYPE_W = 3,
    parameter int K      = 7,
    parameter int L      = 32,
    parameter int ACC_W  = 72,
    localparam int NUM_TYPES = 2 ** TYPE_W,
    localparam int CNT_W     = $clog2(K + 1),
    localparam int VC_W      = $clog2(L + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic              elem_valid_i,
    output logic              elem_ready_o,
    input  logic [W-1:0]      elem_train_i,
    input  logic [W-1:0]      elem_input_i,
    input  logic              elem_last_i,
    input  logic [TYPE_W-1:0] vec_type_i,
    output logic              busy_o,
    output logic [TYPE_W-1:0] inferred_type_o,
    output logic [CNT_W-1:0]  vote_count_o,
    output logic              inference_done_o
);
    typedef enum logic [2:0] {IDLE, ACCUM, INSERT, VOTE, DONE} state_t;

    state_t              state_q, state_d;
    logic                mode_q;
    logic [ACC_W-1:0]    acc_q;
    logic [VC_W-1:0]     vec_cnt_q;
    logic [TYPE_W-1:0]   vtype_q;
    logic [TYPE_W-1:0]   vote_t_q;
    logic [CNT_W-1:0]    best_cnt_q, best_rank_q;
    logic [TYPE_W-1:0]   best_type_q;
    logic [TYPE_W-1:0]   inferred_type_q;
    logic [CNT_W-1:0]    vote_count_q;
    logic                done_q;
    logic [ACC_W-1:0]    dist_q [K];
    logic [TYPE_W-1:0]   typ_q  [K];
    logic                vld_q  [K];

    logic                beat;
    logic [W-1:0]        diff;
    logic [2*W-1:0]      sq;
    logic [ACC_W-1:0]    term;
    logic [ACC_W:0]      sum;
    logic [ACC_W-1:0]    acc_next;

    assign beat         = elem_valid_i && elem_ready_o;
    assign elem_ready_o = (state_q == ACCUM) && !start_i;
    assign busy_o       = (state_q != IDLE);
    assign diff         = (elem_train_i >= elem_input_i) ? (elem_train_i - elem_input_i)
                                                         : (elem_input_i - elem_train_i);
    assign sq           = {{W{1'b0}}, diff} * {{W{1'b0}}, diff};
    assign term         = mode_q ? ACC_W'(sq) : ACC_W'(diff);
    assign sum          = {1'b0, acc_q} + {1'b0, term};
    assign acc_next     = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

    // ins[i]: slot i is at or after the insertion point (list is sorted, so this is monotonic)
    logic [K-1:0]        ins, ins_prev;
    logic [ACC_W-1:0]    n_dist [K];
    logic [TYPE_W-1:0]   n_typ  [K];
    logic                n_vld  [K];
    logic [ACC_W-1:0]    p_dist [K];
    logic [TYPE_W-1:0]   p_typ  [K];
    logic                p_vld  [K];

    always_comb begin
        ins      = '0;
        ins_prev = '0;
        for (int i = 0; i < K; i++) begin
            ins[i]    = !vld_q[i] || (dist_q[i] > acc_q);
            p_dist[i] = acc_q;
            p_typ[i]  = vtype_q;
            p_vld[i]  = 1'b1;
        end
        for (int i = 1; i < K; i++) begin
            ins_prev[i] = ins[i-1];
            p_dist[i]   = dist_q[i-1];
            p_typ[i]    = typ_q[i-1];
            p_vld[i]    = vld_q[i-1];
        end
        for (int i = 0; i < K; i++) begin
            n_dist[i] = dist_q[i];
            n_typ[i]  = typ_q[i];
            n_vld[i]  = vld_q[i];
            if (ins[i] && !ins_prev[i]) begin
                n_dist[i] = acc_q;
                n_typ[i]  = vtype_q;
                n_vld[i]  = 1'b1;
            end else if (ins[i]) begin
                n_dist[i] = p_dist[i];
                n_typ[i]  = p_typ[i];
                n_vld[i]  = p_vld[i];
            end
        end
    end

    logic [CNT_W-1:0] v_cnt, v_rank;
    logic             v_found, v_win;

    always_comb begin
        v_cnt   = '0;
        v_rank  = '0;
        v_found = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (vld_q[i] && (typ_q[i] == vote_t_q)) begin
                v_cnt = v_cnt + CNT_W'(1);
                if (!v_found) begin
                    v_rank  = CNT_W'(i);
                    v_found = 1'b1;
                end
            end
        end
        v_win = (v_cnt > best_cnt_q) ||
                ((v_cnt == best_cnt_q) && (v_cnt != '0) && (v_rank < best_rank_q));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = ACCUM;
            ACCUM:   if (!start_i && beat && elem_last_i) state_d = INSERT;
            INSERT:  if (start_i || (32'(vec_cnt_q) + 1 < L)) state_d = ACCUM;
                     else state_d = VOTE;
            VOTE:    if (start_i) state_d = ACCUM;
                     else if (vote_t_q == TYPE_W'(NUM_TYPES - 1)) state_d = DONE;
            DONE:    state_d = start_i ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            mode_q          <= 1'b0;
            acc_q           <= '0;
            vec_cnt_q       <= '0;
            vtype_q         <= '0;
            vote_t_q        <= '0;
            best_cnt_q      <= '0;
            best_rank_q     <= '0;
            best_type_q     <= '0;
            inferred_type_q <= '0;
            vote_count_q    <= '0;
            done_q          <= 1'b0;
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= '0;
                typ_q[i]  <= '0;
                vld_q[i]  <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (start_i) begin
                mode_q    <= mode_i;
                acc_q     <= '0;
                vec_cnt_q <= '0;
                for (int i = 0; i < K; i++) vld_q[i] <= 1'b0;
            end else begin
                case (state_q)
                    ACCUM: if (beat) begin
                        acc_q <= acc_next;
                        if (elem_last_i) vtype_q <= vec_type_i;
                    end
                    INSERT: begin
                        for (int i = 0; i < K; i++) begin
                            dist_q[i] <= n_dist[i];
                            typ_q[i]  <= n_typ[i];
                            vld_q[i]  <= n_vld[i];
                        end
                        acc_q       <= '0;
                        vec_cnt_q   <= vec_cnt_q + VC_W'(1);
                        vote_t_q    <= '0;
                        best_cnt_q  <= '0;
                        best_rank_q <= '0;
                        best_type_q <= '0;
                    end
                    VOTE: begin
                        vote_t_q <= vote_t_q + TYPE_W'(1);
                        if (v_win) begin
                            best_cnt_q  <= v_cnt;
                            best_rank_q <= v_rank;
                            best_type_q <= vote_t_q;
                        end
                    end
                    default: ;
                endcase
            end
            if (state_q == DONE) begin
                inferred_type_q <= best_type_q;
                vote_count_q    <= best_cnt_q;
                done_q          <= 1'b1;
            end
        end
    end

    assign inferred_type_o  = inferred_type_q;
    assign vote_count_o     = vote_count_q;
    assign inference_done_o = done_q;
endmodule

// File: tb/tb_knn_stream_classifier.sv
// tb/tb_knn_stream_classifier.sv - directed self-checking bench for knn_stream_classifier
module tb_knn_stream_classifier;
    logic        clk = 1'b0;
    logic        rst, start, mode, elem_valid, elem_ready, elem_last, busy, inference_done;
    logic [31:0] elem_train, elem_input;
    logic [2:0]  vec_type, inferred_type, vote_count;

    int passed = 0;
    int total  = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_acc_cyc = 0;
    int vals [32];
    int typs [32];

    knn_stream_classifier #(.W(32), .TYPE_W(3), .K(7), .L(32), .ACC_W(72)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
        .elem_valid_i(elem_valid), .elem_ready_o(elem_ready),
        .elem_train_i(elem_train), .elem_input_i(elem_input),
        .elem_last_i(elem_last), .vec_type_i(vec_type), .busy_o(busy),
        .inferred_type_o(inferred_type), .vote_count_o(vote_count),
        .inference_done_o(inference_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (inference_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = ~m;
    endtask

    task automatic beat(input logic [31:0] tr, input logic [31:0] inp, input logic last,
                        input logic [2:0] ty, input bit gaps);
        bit got = 0;
        int n = 0;
        if (gaps) begin
            elem_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        elem_valid = 1'b1;
        elem_train = tr;
        elem_input = inp;
        elem_last  = last;
        vec_type   = ty;
        while (!got && n < 100) begin
            @(negedge clk);
            got = elem_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!got) check("beat_accept", 32'(got), 1);
        last_acc_cyc = cyc;
    endtask

    task automatic feed(input logic m, input int query, input bit gaps, input int big, input int nvec);
        pulse_start(m);
        for (int v = 0; v < nvec; v++) begin
            if (v == big) begin
                for (int b = 0; b < 256; b++) beat(32'hFFFF_FFFF, 0, 1'b0, 3'(typs[v]), gaps);
                beat(32'hFFFF_FFFF, 0, 1'b1, 3'(typs[v]), gaps);
            end else begin
                beat(32'(vals[v]), 32'(query), 1'b1, 3'(typs[v]), gaps);
            end
        end
        elem_valid = 1'b0;
        elem_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_type, input int exp_cnt);
        bit seen = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (inference_done) seen = 1;
        end
        check({tag, "_done"}, 32'(seen), 1);
        check({tag, "_type"}, 32'(inferred_type), 32'(exp_type));
        check({tag, "_votes"}, 32'(vote_count), 32'(exp_cnt));
        check({tag, "_latency"}, 32'(cyc - last_acc_cyc), 10);
        check({tag, "_busy_at_done"}, 32'(busy), 0);
    endtask

    task automatic load_t1();
        for (int i = 0; i < 32; i++) begin
            vals[i] = i;
            typs[i] = i / 4;
        end
    endtask

    task automatic load_t2();
        int v7 [7] = '{1, 2, 3, 4, 5, 6, 7};
        int t7 [7] = '{1, 4, 4, 1, 4, 1, 5};
        for (int i = 0; i < 25; i++) begin
            vals[i] = 100;
            typs[i] = 0;
        end
        for (int i = 0; i < 7; i++) begin
            vals[25 + i] = v7[i];
            typs[25 + i] = t7[i];
        end
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; mode = 1'b0; elem_valid = 1'b0; elem_last = 1'b0;
        elem_train = '0; elem_input = '0; vec_type = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_ready", 32'(elem_ready), 0);
        check("reset_done", 32'(inference_done), 0);
        check("reset_type", 32'(inferred_type), 0);
        check("reset_votes", 32'(vote_count), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: L1 ordering, expect type 2 with 4 votes
        load_t1();
        feed(1'b0, 10, 1'b0, -1, 32);
        wait_done("t1", 2, 4);
        repeat (5) @(posedge clk);
        #1;
        check("t1_hold_type", 32'(inferred_type), 2);
        check("t1_single_pulse", 32'(done_cnt), 1);

        // T2: 3-3 tie resolved to the type holding the nearest neighbour
        load_t2();
        feed(1'b0, 0, 1'b0, -1, 32);
        wait_done("t2", 1, 3);

        // T3: squared L2 with a saturating 257-beat vector in the last slot
        load_t1();
        feed(1'b1, 10, 1'b0, 31, 32);
        wait_done("t3", 2, 4);

        // T4: T1 data with random valid gaps
        load_t1();
        feed(1'b0, 10, 1'b1, -1, 32);
        wait_done("t4", 2, 4);

        // T5: abort after 10 vectors, then T2 data
        @(posedge clk); #1;
        d0 = done_cnt;
        load_t1();
        feed(1'b0, 10, 1'b0, -1, 10);
        load_t2();
        feed(1'b0, 0, 1'b0, -1, 32);
        wait_done("t5", 1, 3);
        repeat (3) @(posedge clk);
        #1;
        check("t5_one_done", 32'(done_cnt - d0), 1);

        // T6: reset during VOTE, then a clean T1 run
        load_t1();
        feed(1'b0, 10, 1'b0, -1, 32);
        repeat (3) @(posedge clk);
        #1;
        check("t6_busy_in_vote", 32'(busy), 1);
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_type", 32'(inferred_type), 0);
        check("t6_rst_votes", 32'(vote_count), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_done", 32'(inference_done), 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t6_no_done", 32'(done_cnt - d0), 0);
        feed(1'b0, 10, 1'b0, -1, 32);
        wait_done("t6_rerun", 2, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
